bcd_mod_counter: RTL and testbench

BCD_MOD_COUNTER -- requirements
Module: bcd_mod_counter

---
 rtl/bcd_mod_counter_pkg.sv | 15 +
 rtl/bcd_mod_counter_if.sv | 25 ++
 rtl/bcd_mod_counter_digit.sv | 24 ++
 rtl/bcd_mod_counter.sv | 70 +++++++
 tb/tb_bcd_mod_counter.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/bcd_mod_counter_pkg.sv
// Shared BCD types and helpers for the modulo-N two-decade counter.
package bcd_mod_counter_pkg;
  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  // Tens and units digits of MODULUS-1, the terminal value of the count.
  function automatic bcd_digit_t top_high(input int m);
    return bcd_digit_t'((m - 1) / 10);
  endfunction

  function automatic bcd_digit_t top_low(input int m);
    return bcd_digit_t'((m - 1) % 10);
  endfunction
endpackage

// File: rtl/bcd_mod_counter_if.sv
// Control/preset inputs and BCD count outputs of one counter stage.
interface bcd_mod_counter_if;
  import bcd_mod_counter_pkg::*;

  logic       en;
  logic       dir;
  logic       load;
  bcd_digit_t load_low;
  bcd_digit_t load_high;
  bcd_digit_t cnt_low;
  bcd_digit_t cnt_high;
  logic       carry;
  logic       tc;
  logic       load_err;

  modport master (
    output en, dir, load, load_low, load_high,
    input  cnt_low, cnt_high, carry, tc, load_err
  );

  modport slave (
    input  en, dir, load, load_low, load_high,
    output cnt_low, cnt_high, carry, tc, load_err
  );
endinterface

// File: rtl/bcd_mod_counter_digit.sv
// One BCD decade: load, increment or decrement with a programmable wrap digit.
module bcd_digit
  import bcd_mod_counter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  input  logic       ld,
  input  bcd_digit_t ld_val,
  input  bcd_digit_t wrap_val,
  output bcd_digit_t q,
  output logic       co
);
  // co is carry on increment and borrow on decrement; it feeds the next decade.
  assign co = (inc && q == wrap_val) || (dec && q == 4'd0);

  always_ff @(posedge clk) begin
    if (rst)      q <= 4'd0;
    else if (ld)  q <= ld_val;
    else if (inc) q <= (q == wrap_val) ? 4'd0 : q + 4'd1;
    else if (dec) q <= (q == 4'd0) ? wrap_val : q - 4'd1;
  end
endmodule

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo-MODULUS counter with preset, optional down count and cascade carry.
module bcd_mod_counter
  import bcd_mod_counter_pkg::*;
#(
  parameter int MODULUS = 60,
  parameter bit DOWN_EN = 1'b0
) (
  input logic             clk,
  input logic             rst,
  bcd_mod_counter_if.slave bus
);
  localparam bcd_digit_t TOP_H = top_high(MODULUS);
  localparam bcd_digit_t TOP_L = top_low(MODULUS);

  generate
    if (MODULUS < 2 || MODULUS > 99) begin : g_bad_modulus
      $error("bcd_mod_counter: MODULUS must be in 2..99");
    end
  endgenerate

  bcd_digit_t lo_q, hi_q, lo_val, hi_val;
  logic       lo_co, hi_co;
  logic       down, at_max, at_zero, load_ok, wrap, step, ld;
  logic [6:0] preset;

  assign down    = bus.dir & DOWN_EN;
  assign at_max  = (hi_q == TOP_H) && (lo_q == TOP_L);
  assign at_zero = (hi_q == 4'd0) && (lo_q == 4'd0);

  assign preset  = 7'(bus.load_high) * 7'd10 + 7'(bus.load_low);
  assign load_ok = (bus.load_high <= BCD_MAX) && (bus.load_low <= BCD_MAX) &&
                   (preset < 7'(MODULUS));

  // Full-value wrap is applied as a preset of both digits so a short top decade
  // (e.g. 23 -> 00) never relies on per-digit rollover.
  assign wrap    = bus.en && !bus.load && (down ? at_zero : at_max);
  assign step    = bus.en && !bus.load && !wrap;
  assign ld      = (bus.load && load_ok) || wrap;
  assign lo_val  = bus.load ? bus.load_low  : (down ? TOP_L : 4'd0);
  assign hi_val  = bus.load ? bus.load_high : (down ? TOP_H : 4'd0);

  bcd_digit u_low (
    .clk(clk), .rst(rst),
    .inc(step && !down), .dec(step && down),
    .ld(ld), .ld_val(lo_val), .wrap_val(BCD_MAX),
    .q(lo_q), .co(lo_co)
  );

  bcd_digit u_high (
    .clk(clk), .rst(rst),
    .inc(lo_co && !down), .dec(lo_co && down),
    .ld(ld), .ld_val(hi_val), .wrap_val(TOP_H),
    .q(hi_q), .co(hi_co)
  );

  // A tens rollover is also a wrap; it cannot occur while the count is in range.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.carry    <= 1'b0;
      bus.load_err <= 1'b0;
    end else begin
      bus.carry    <= wrap || hi_co;
      bus.load_err <= bus.load && !load_ok;
    end
  end

  assign bus.cnt_low  = lo_q;
  assign bus.cnt_high = hi_q;
  assign bus.tc       = down ? at_zero : at_max;
endmodule

// File: tb/tb_bcd_mod_counter.sv
// Random and directed checks of bcd_mod_counter against an integer reference model.
module tb_bcd_mod_counter;
  import bcd_mod_counter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic cen;
  always #5 clk = ~clk;

  bcd_mod_counter_if i60 ();
  bcd_mod_counter_if i24 ();
  bcd_mod_counter_if imin ();
  bcd_mod_counter_if ihr ();

  bcd_mod_counter #(.MODULUS(60), .DOWN_EN(1'b1)) u60  (.clk(clk), .rst(rst), .bus(i60));
  bcd_mod_counter #(.MODULUS(24), .DOWN_EN(1'b0)) u24  (.clk(clk), .rst(rst), .bus(i24));
  bcd_mod_counter #(.MODULUS(60), .DOWN_EN(1'b0)) umin (.clk(clk), .rst(rst), .bus(imin));
  bcd_mod_counter #(.MODULUS(24), .DOWN_EN(1'b0)) uhr  (.clk(clk), .rst(rst), .bus(ihr));

  assign imin.en = cen;
  assign ihr.en  = imin.carry;

  int n_cmp = 0, n_bad = 0;
  int m60 = 0, m24 = 0, car60 = 0, car24 = 0, err60 = 0, err24 = 0;
  int min_car = 0, hr_car = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int bcd2(input int v);
    return (v / 10) * 16 + (v % 10);
  endfunction

  // Count as an integer 0..M-1; wrap is modular arithmetic.
  task automatic model(input int m, input bit dn, input bit r, input bit e, input bit d,
                       input bit l, input int lh, input int ll,
                       inout int c, output int car, output int er);
    car = 0;
    er  = 0;
    if (r) c = 0;
    else if (l) begin
      if (lh <= 9 && ll <= 9 && lh * 10 + ll < m) c = lh * 10 + ll;
      else er = 1;
    end else if (e) begin
      if (dn && d) begin car = (c == 0);     c = (c + m - 1) % m; end
      else         begin car = (c == m - 1); c = (c + 1) % m;     end
    end
  endtask

  task automatic step(input bit r, input bit e, input bit d, input bit l,
                      input int lh, input int ll, input bit cn);
    rst = r;
    cen = cn;
    i60.en = e; i60.dir = d; i60.load = l; i60.load_high = 4'(lh); i60.load_low = 4'(ll);
    i24.en = e; i24.dir = d; i24.load = l; i24.load_high = 4'(lh); i24.load_low = 4'(ll);
    #1;
    chk("tc60", int'(i60.tc), d ? int'(m60 == 0) : int'(m60 == 59));
    chk("tc24", int'(i24.tc), int'(m24 == 23));
    @(posedge clk);
    #1;
    model(60, 1'b1, r, e, d, l, lh, ll, m60, car60, err60);
    model(24, 1'b0, r, e, d, l, lh, ll, m24, car24, err24);
    chk("cnt60",   int'({i60.cnt_high, i60.cnt_low}), bcd2(m60));
    chk("carry60", int'(i60.carry), car60);
    chk("lerr60",  int'(i60.load_err), err60);
    chk("cnt24",   int'({i24.cnt_high, i24.cnt_low}), bcd2(m24));
    chk("carry24", int'(i24.carry), car24);
    chk("lerr24",  int'(i24.load_err), err24);
    if (imin.carry) min_car++;
    if (ihr.carry)  hr_car++;
    @(negedge clk);
  endtask

  initial begin
    int wraps;
    rst = 1'b1; cen = 1'b0;
    i60.en = 0; i60.dir = 0; i60.load = 0; i60.load_high = 0; i60.load_low = 0;
    i24.en = 0; i24.dir = 0; i24.load = 0; i24.load_high = 0; i24.load_low = 0;
    imin.dir = 0; imin.load = 0; imin.load_high = 0; imin.load_low = 0;
    ihr.dir = 0;  ihr.load = 0;  ihr.load_high = 0;  ihr.load_low = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cnt60",   int'({i60.cnt_high, i60.cnt_low}), 0);
    chk("rst_carry60", int'(i60.carry), 0);
    chk("rst_lerr60",  int'(i60.load_err), 0);
    chk("rst_cnt24",   int'({i24.cnt_high, i24.cnt_low}), 0);
    rst = 1'b0;

    // 120 free-running steps: two wraps of the mod-60 stage
    wraps = 0;
    for (int i = 0; i < 120; i++) begin
      step(0, 1, 0, 0, 0, 0, 0);
      if (i60.carry) wraps++;
    end
    chk("wraps120", wraps, 2);
    chk("end120", int'({i60.cnt_high, i60.cnt_low}), 0);

    // mod-24 preset at terminal, wrap, then out-of-range preset
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 2, 3, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    chk("wrap24_carry", int'(i24.carry), 1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("wrap24_pulse", int'(i24.carry), 0);
    step(0, 0, 0, 1, 2, 4, 0);
    chk("load24_err", int'(i24.load_err), 1);
    step(0, 0, 0, 1, 10, 2, 0);
    step(0, 0, 0, 1, 1, 12, 0);

    // down count: 00 -> 59 with carry, 10 -> 09 without
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    chk("down_wrap", int'({i60.cnt_high, i60.cnt_low}), 8'h59);
    step(0, 0, 1, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    chk("down_borrow", int'({i60.cnt_high, i60.cnt_low}), 8'h09);
    step(0, 1, 0, 0, 0, 0, 0);

    // load beats en; reset beats a wrapping step
    step(0, 1, 0, 1, 4, 5, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    chk("after45", int'({i60.cnt_high, i60.cnt_low}), 8'h46);
    step(0, 0, 0, 1, 5, 9, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 2, 3, 0);
    step(0, 1, 1, 1, 0, 0, 0);

    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0, 1'($urandom),
           $urandom_range(0, 7) == 0, $urandom_range(0, 11), $urandom_range(0, 11), 0);

    // cascade: one day of minute ticks
    step(1, 0, 0, 0, 0, 0, 0);
    min_car = 0;
    hr_car  = 0;
    for (int i = 0; i < 1440; i++) step(0, 0, 0, 0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);
    chk("casc_min_cnt", int'({imin.cnt_high, imin.cnt_low}), 0);
    chk("casc_hr_cnt",  int'({ihr.cnt_high, ihr.cnt_low}), 0);
    chk("casc_min_car", min_car, 24);
    chk("casc_hr_car",  hr_car, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
